// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction memory request/response, branch redirect,
// and the IF/ID delivery handshake. master = fetch_queue, slave = its environment.
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [63:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [63:0]   if_pc;
  logic [31:0]   if_inst;
  logic [CW-1:0] queue_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_pc,
    output if_valid, if_pc, if_inst, queue_count,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_pc,
    input  if_valid, if_pc, if_inst, queue_count,
    output if_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues in-order word fetches,
// buffers {pc, inst} until IF/ID takes them, and discards wrong-path words
// still in flight after a taken-branch redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]             fetch_pc;
  logic [DEPTH-1:0][63:0]  ent_pc;
  logic [DEPTH-1:0][31:0]  ent_inst;
  logic [DEPTH-1:0]        ent_filled;
  logic [PW-1:0]           alloc_ptr, fill_ptr, head_ptr;
  // count: allocated entries; pend_cnt: allocated but not yet filled;
  // drop_cnt: responses still owed for fetches killed by a redirect
  logic [CW-1:0]           count, pend_cnt, drop_cnt;
  logic [CW-1:0]           occ, drop_redir;
  logic                    alloc, fill, discard, pop;
  logic                    unused_pc_lsb;

  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  // count + drop_cnt never exceeds DEPTH, so CW bits hold the sum
  assign occ                = count + drop_cnt;
  assign bus.imem_req_valid = (occ < CW'(DEPTH)) && !bus.redirect && reset;
  assign bus.imem_req_addr  = fetch_pc;
  assign alloc              = bus.imem_req_valid && bus.imem_req_ready;

  // drop takes precedence; a word with nothing outstanding is ignored
  assign discard = bus.imem_rsp_valid && (drop_cnt != '0);
  assign fill    = bus.imem_rsp_valid && (drop_cnt == '0) && (pend_cnt != '0);

  assign bus.if_valid    = (count != '0) && ent_filled[head_ptr];
  assign bus.if_pc       = ent_pc[head_ptr];
  assign bus.if_inst     = ent_inst[head_ptr];
  assign bus.queue_count = count;
  assign pop             = bus.if_valid && bus.if_ready && !bus.redirect;

  // Responses owed after a redirect: every unfilled fetch, less the word
  // that arrives (and is thrown away) in the redirect cycle itself
  always_comb begin
    drop_redir = drop_cnt + pend_cnt;
    if (bus.imem_rsp_valid && (drop_redir != '0))
      drop_redir = drop_redir - CW'(1);
  end

  // Pointers, counters and fetch PC; redirect overrides all other events
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (bus.redirect) begin
      fetch_pc  <= {bus.redirect_pc[63:2], 2'b00};
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_redir;
    end else begin
      if (alloc) begin
        fetch_pc  <= fetch_pc + 64'd4;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill)    fill_ptr <= fill_ptr + PW'(1);
      if (pop)     head_ptr <= head_ptr + PW'(1);
      if (discard) drop_cnt <= drop_cnt - CW'(1);
      count    <= count + CW'(alloc) - CW'(pop);
      pend_cnt <= pend_cnt + CW'(alloc) - CW'(fill);
    end
  end

  // Entry storage; alloc, fill and pop never target the same slot in a cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_pc     <= '0;
      ent_inst   <= '0;
      ent_filled <= '0;
    end else if (bus.redirect) begin
      ent_filled <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && alloc_ptr == PW'(i)) begin
          ent_pc[i]     <= fetch_pc;
          ent_filled[i] <= 1'b0;
        end
        if (fill && fill_ptr == PW'(i)) begin
          ent_inst[i]   <= bus.imem_rsp_data;
          ent_filled[i] <= 1'b1;
        end
        if (pop && head_ptr == PW'(i))
          ent_filled[i] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable in-order memory model.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic clk = 1'b0;
  logic reset;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  req_t pend_q[$];
  int   cyc_n, lat;
  bit   rnd;
  int   errors, checks;

  logic        o_req_v, o_if_v, o_pop;
  logic [63:0] o_req_addr, o_if_pc;
  logic [31:0] o_if_inst;
  logic [2:0]  o_count, o_drop;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
  endfunction

  // One clock: drive memory response, sample outputs before the edge, then step
  task automatic cyc();
    if (rnd) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.if_ready       = ($urandom_range(0, 3) != 0);
    end
    if (pend_q.size() != 0 && pend_q[0].due <= cyc_n && (!rnd || $urandom_range(0, 2) != 0)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #2;
    o_req_v    = bus.imem_req_valid;
    o_req_addr = bus.imem_req_addr;
    o_if_v     = bus.if_valid;
    o_if_pc    = bus.if_pc;
    o_if_inst  = bus.if_inst;
    o_count    = bus.queue_count;
    o_drop     = dut.drop_cnt;
    o_pop      = bus.if_valid && bus.if_ready;
    if (bus.imem_rsp_valid) void'(pend_q.pop_front());
    if (o_req_v && bus.imem_req_ready) pend_q.push_back('{bus.imem_req_addr, cyc_n + lat});
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rnd = 1'b0;
    bus.redirect = 1'b0;
    pend_q.delete();
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pend_q.delete();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    repeat (2) begin
      cyc();
      checks++; if (o_req_v !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", o_req_v); end
      checks++; if (o_if_v !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%b exp=0", o_if_v); end
      checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    end
    reset = 1'b1;
    cyc();
    checks++; if (o_req_v !== 1'b1) begin errors++; $display("FAIL reset_first_req got=%b exp=1", o_req_v); end
    checks++; if (o_req_addr !== RESET_PC) begin errors++; $display("FAIL reset_first_addr got=%h exp=%h", o_req_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [63:0] epc;
    do_reset();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++; if (o_req_v !== 1'b1 || o_req_addr !== 64'(4 * (i - 1)))
        begin errors++; $display("FAIL stream_req c%0d got=%b/%h exp=1/%h", i, o_req_v, o_req_addr, 4 * (i - 1)); end
      if (i < 3) begin
        checks++; if (o_if_v !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d got=%b exp=0", i, o_if_v); end
      end else begin
        epc = 64'(4 * (i - 3));
        checks++; if (o_if_v !== 1'b1 || o_if_pc !== epc || o_if_inst !== mem_word(epc))
          begin errors++; $display("FAIL stream_deliver c%0d got=%b/%h/%h exp=1/%h/%h", i, o_if_v, o_if_pc, o_if_inst, epc, mem_word(epc)); end
      end
    end
  endtask

  task automatic test_full();
    int acc;
    do_reset();
    lat = 1;
    acc = 0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    repeat (8) begin
      cyc();
      if (o_req_v) acc++;
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL full_accepted got=%0d exp=4", acc); end
    checks++; if (o_req_v !== 1'b0) begin errors++; $display("FAIL full_req_valid got=%b exp=0", o_req_v); end
    checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", o_count); end
    bus.if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++; if (o_if_v !== 1'b1 || o_if_pc !== 64'(4 * k) || o_if_inst !== mem_word(64'(4 * k)))
        begin errors++; $display("FAIL full_pop%0d got=%b/%h exp=1/%h", k, o_if_v, o_if_pc, 4 * k); end
      if (k == 0) begin
        checks++; if (o_req_v !== 1'b0) begin errors++; $display("FAIL full_req_at_pop got=%b exp=0", o_req_v); end
      end
      if (k == 1) begin
        checks++; if (o_req_v !== 1'b1 || o_req_addr !== 64'h10)
          begin errors++; $display("FAIL full_reissue got=%b/%h exp=1/10", o_req_v, o_req_addr); end
      end
    end
  endtask

  task automatic test_redirect();
    int n;
    do_reset();
    lat = 3;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    cyc();
    cyc();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h1002;
    cyc();
    checks++; if (o_req_v !== 1'b0) begin errors++; $display("FAIL redir_req_in_cycle got=%b exp=0", o_req_v); end
    bus.redirect = 1'b0;
    cyc();
    checks++; if (o_req_v !== 1'b1 || o_req_addr !== 64'h1000)
      begin errors++; $display("FAIL redir_new_req got=%b/%h exp=1/1000", o_req_v, o_req_addr); end
    checks++; if (o_if_v !== 1'b0) begin errors++; $display("FAIL redir_if_valid got=%b exp=0", o_if_v); end
    checks++; if (o_drop !== 3'd2) begin errors++; $display("FAIL redir_drop_start got=%0d exp=2", o_drop); end
    cyc();
    cyc();
    checks++; if (o_drop !== 3'd0) begin errors++; $display("FAIL redir_drop_end got=%0d exp=0", o_drop); end
    n = 0;
    while (!o_if_v && n < 20) begin cyc(); n++; end
    checks++; if (o_if_v !== 1'b1 || o_if_pc !== 64'h1000 || o_if_inst !== mem_word(64'h1000))
      begin errors++; $display("FAIL redir_first_pc got=%b/%h exp=1/1000", o_if_v, o_if_pc); end
  endtask

  task automatic test_redirect_rsp();
    logic [63:0] epc;
    int n;
    do_reset();
    lat = 3;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    repeat (3) cyc();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h2000;
    cyc();
    checks++; if (o_req_v !== 1'b0) begin errors++; $display("FAIL rrsp_req_in_cycle got=%b exp=0", o_req_v); end
    bus.redirect = 1'b0;
    cyc();
    checks++; if (o_drop !== 3'd2) begin errors++; $display("FAIL rrsp_drop got=%0d exp=2", o_drop); end
    epc = 64'h2000;
    n = 0;
    repeat (30) begin
      cyc();
      if (o_if_v) begin
        checks++; if (o_if_pc !== epc || o_if_inst !== mem_word(epc))
          begin errors++; $display("FAIL rrsp_deliver got=%h/%h exp=%h/%h", o_if_pc, o_if_inst, epc, mem_word(epc)); end
        epc = epc + 64'd4;
        n++;
      end
    end
    checks++; if (n < 10) begin errors++; $display("FAIL rrsp_count got=%0d exp>=10", n); end
  endtask

  task automatic test_random();
    logic [63:0] epc;
    int n, budget;
    do_reset();
    lat = 1;
    rnd = 1'b1;
    epc = RESET_PC;
    n = 0;
    budget = 20000;
    while (n < 1000 && budget > 0) begin
      cyc();
      budget--;
      if (o_pop) begin
        checks++; if (o_if_pc !== epc || o_if_inst !== mem_word(epc))
          begin errors++; $display("FAIL rand_deliver n=%0d got=%h/%h exp=%h/%h", n, o_if_pc, o_if_inst, epc, mem_word(epc)); end
        epc = epc + 64'd4;
        n++;
      end
    end
    rnd = 1'b0;
    checks++; if (n != 1000) begin errors++; $display("FAIL rand_timeout got=%0d exp=1000", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (2) begin
      cyc();
      checks++; if (o_req_v !== 1'b0) begin errors++; $display("FAIL mid_req_valid got=%b exp=0", o_req_v); end
      checks++; if (o_if_v !== 1'b0) begin errors++; $display("FAIL mid_if_valid got=%b exp=0", o_if_v); end
      checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", o_count); end
    end
    pend_q.delete();
    pend_q.push_back('{64'h80, cyc_n});
    reset = 1'b1;
    bus.if_ready = 1'b1;
    cyc();
    checks++; if (o_req_v !== 1'b1 || o_req_addr !== RESET_PC)
      begin errors++; $display("FAIL mid_first_req got=%b/%h exp=1/%h", o_req_v, o_req_addr, RESET_PC); end
    n = 0;
    while (!o_if_v && n < 10) begin cyc(); n++; end
    checks++; if (o_if_v !== 1'b1 || o_if_pc !== RESET_PC || o_if_inst !== mem_word(RESET_PC))
      begin errors++; $display("FAIL mid_first_inst got=%b/%h/%h exp=1/%h/%h", o_if_v, o_if_pc, o_if_inst, RESET_PC, mem_word(RESET_PC)); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc_n = 0;
    lat = 1;
    rnd = 1'b0;
    reset = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.if_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_rsp();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
